// File: rtl/line_reduction_engine.sv
// line_reduction_engine: walks a chord pixel by pixel (integer Bresenham), issues one
// image/weight SRAM read per on-image pixel and accumulates the sum of pixel*weight.
// Optional build macro: REDUCTION_SAT_EN -- accumulator saturates at all-ones instead
// of wrapping modulo 2^ACC_W.
module line_reduction_engine #(
  parameter int COORD_W = 10,
  parameter int PIX_W   = 9,
  parameter int WT_W    = 4,
  parameter int ACC_W   = 19,
  parameter int ADDR_W  = 19,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [PIX_W-1:0]   image_sram_in,
  input  logic [WT_W-1:0]    weight_sram_in,
  output logic               sram_rd,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   reduction
);

  localparam int EW = COORD_W + 2;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int PW = PIX_W + WT_W;
  localparam int unsigned IMG_WU = IMG_W;
  localparam int unsigned IMG_HU = IMG_H;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [COORD_W-1:0]        x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
  logic [COORD_W-1:0]        dx_q, dx_d, dy_q, dy_d;
  logic                      sx_q, sx_d, sy_q, sy_d;
  logic signed [EW-1:0]      err_q, err_d;
  logic [CW-1:0]             drn_q, drn_d;
  logic [RD_LAT-1:0]         vld_q;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [ADDR_W-1:0]         addr_q;

  logic                      in_img, last_px, step_x, step_y;
  logic [ADDR_W-1:0]         cur_addr;
  logic signed [EW:0]        e2, dx_s, dy_s, err_w;
  logic [COORD_W-1:0]        dx_n, dy_n;
  logic [PW-1:0]             prod;
  logic [ACC_W:0]            sum;
  logic [ACC_W-1:0]          acc_add;

  // Current pixel address, clipping, Bresenham decision and the accumulate adder.
  always_comb begin
    in_img   = (32'(x_q) < IMG_WU) && (32'(y_q) < IMG_HU);
    cur_addr = ADDR_W'(y_q) * STRIDE + ADDR_W'(x_q);
    sram_rd  = (state_q == S_WALK) && in_img;
    sram_addr = sram_rd ? cur_addr : addr_q;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    reduction = acc_q;
    last_px  = (x_q == xe_q) && (y_q == ye_q);

    e2     = {err_q, 1'b0};
    dx_s   = {3'b000, dx_q};
    dy_s   = {3'b000, dy_q};
    step_x = (e2 > -dy_s);
    step_y = (e2 < dx_s);
    err_w  = {err_q[EW-1], err_q};
    if (step_x) err_w = err_w - dy_s;
    if (step_y) err_w = err_w + dx_s;

    dx_n = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy_n = (y1 >= y0) ? y1 - y0 : y0 - y1;

    prod = {{WT_W{1'b0}}, image_sram_in} * {{PIX_W{1'b0}}, weight_sram_in};
    sum  = {1'b0, acc_q} + {1'b0, ACC_W'(prod)};
`ifdef REDUCTION_SAT_EN
    acc_add = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_add = sum[ACC_W-1:0];
`endif
  end

  // Next-state logic for the walk FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    x_d = x_q;   y_d = y_q;   xe_d = xe_q; ye_d = ye_q;
    dx_d = dx_q; dy_d = dy_q; sx_d = sx_q; sy_d = sy_q;
    err_d = err_q;
    drn_d = drn_q;
    acc_d = vld_q[RD_LAT-1] ? acc_add : acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d  = x0;  y_d  = y0;
          xe_d = x1;  ye_d = y1;
          dx_d = dx_n; dy_d = dy_n;
          sx_d = (x1 < x0);
          sy_d = (y1 < y0);
          err_d = $signed({2'b00, dx_n}) - $signed({2'b00, dy_n});
          acc_d = '0;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (last_px) begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end else begin
          // Both axis tests use the error value from the start of the cycle.
          if (step_x) x_d = sx_q ? x_q - COORD_W'(1) : x_q + COORD_W'(1);
          if (step_y) y_d = sy_q ? y_q - COORD_W'(1) : y_q + COORD_W'(1);
          err_d = err_w[EW-1:0];
        end
      end
      S_DRAIN: begin
        if (drn_q == CW'(RD_LAT - 1)) state_d = S_DONE;
        else                          drn_d = drn_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      x_q <= '0;  y_q <= '0;  xe_q <= '0; ye_q <= '0;
      dx_q <= '0; dy_q <= '0; sx_q <= 1'b0; sy_q <= 1'b0;
      err_q <= '0;
      drn_q <= '0;
      acc_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;   y_q <= y_d;   xe_q <= xe_d; ye_q <= ye_d;
      dx_q <= dx_d; dy_q <= dy_d; sx_q <= sx_d; sy_q <= sy_d;
      err_q <= err_d;
      drn_q <= drn_d;
      acc_q <= acc_d;
      addr_q <= sram_addr;
    end
  end

  // Valid bits travelling beside each read, emerging when its data arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= sram_rd;
      for (int unsigned i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

endmodule

// File: tb/tb_line_reduction_engine.sv
module tb_line_reduction_engine;

  localparam int COORD_W = 10;
  localparam int PIX_W   = 9;
  localparam int WT_W    = 4;
  localparam int ACC_W   = 19;
  localparam int ADDR_W  = 19;
  localparam int IMG_W   = 640;
  localparam int IMG_H   = 480;
  localparam int RD_LAT  = 2;
  localparam longint MAXV = (longint'(1) << ACC_W) - 1;
`ifdef REDUCTION_SAT_EN
  localparam longint DIAG_RED = 524287;
`else
  localparam longint DIAG_RED = 187008;   // 640 * 7665 = 4905600 mod 2^19
`endif

  logic clk = 1'b0, reset, start;
  logic [COORD_W-1:0] x0, y0, x1, y1;
  logic [PIX_W-1:0] image_sram_in;
  logic [WT_W-1:0] weight_sram_in;
  logic sram_rd, busy, done;
  logic [ADDR_W-1:0] sram_addr;
  logic [ACC_W-1:0] reduction;

  line_reduction_engine #(
    .COORD_W(COORD_W), .PIX_W(PIX_W), .WT_W(WT_W), .ACC_W(ACC_W),
    .ADDR_W(ADDR_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .image_sram_in(image_sram_in), .weight_sram_in(weight_sram_in),
    .sram_rd(sram_rd), .sram_addr(sram_addr),
    .busy(busy), .done(done), .reduction(reduction)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  bit const_mode = 1'b1;
  int unsigned cpix = 0, cwt = 0, salt = 0;
  int unsigned cap_q[$];
  int unsigned exp_q[$];

  function automatic int unsigned pix_of(input int unsigned a);
    return const_mode ? cpix : ((a * 13 + salt) % 512);
  endfunction
  function automatic int unsigned wt_of(input int unsigned a);
    return const_mode ? cwt : ((a * 7 + (salt >> 9)) % 16);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // SRAM model: answers each read RD_LAT cycles later, junk otherwise; logs addresses.
  bit          pv[RD_LAT+1];
  int unsigned pa[RD_LAT+1];
  always @(negedge clk) begin
    for (int i = RD_LAT; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = sram_rd;
    pa[0] = sram_addr;
    if (sram_rd) cap_q.push_back(sram_addr);
    if (pv[RD_LAT]) begin
      image_sram_in  = PIX_W'(pix_of(pa[RD_LAT]));
      weight_sram_in = WT_W'(wt_of(pa[RD_LAT]));
    end else begin
      image_sram_in  = PIX_W'($urandom);
      weight_sram_in = WT_W'($urandom);
    end
  end

  // Reference: pixel list from the chord rule, with clipping and the accumulator rule.
  task automatic model(input int ax0, ay0, ax1, ay1, output int n, output longint s);
    int x, y, dx, dy, sx, sy, err, e2;
    int unsigned a;
    exp_q.delete();
    x = ax0; y = ay0;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx - dy;
    n = 0; s = 0;
    for (int k = 0; k < 4096; k++) begin
      n++;
      if (x < IMG_W && y < IMG_H) begin
        a = y * IMG_W + x;
        exp_q.push_back(a);
        s = s + longint'(pix_of(a)) * longint'(wt_of(a));
`ifdef REDUCTION_SAT_EN
        if (s > MAXV) s = MAXV;
`else
        s = s % (MAXV + 1);
`endif
      end
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 > -dy) begin err -= dy; x += sx; end
      if (e2 < dx)  begin err += dx; y += sy; end
    end
  endtask

  task automatic check_chord(input string nm, input int ax0, ay0, ax1, ay1, input int inject,
                             output int dcyc, output longint red, output int nrd);
    int n, busy_bad, mism;
    longint es;
    model(ax0, ay0, ax1, ay1, n, es);
    @(negedge clk);
    cap_q.delete();
    x0 = COORD_W'(ax0); y0 = COORD_W'(ay0); x1 = COORD_W'(ax1); y1 = COORD_W'(ay1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcyc = -1; busy_bad = 0;
    for (int c = 1; c <= 3000; c++) begin
      if (!busy) busy_bad++;
      if (done) begin dcyc = c; break; end
      if (c == inject) begin
        x0 = COORD_W'($urandom_range(0, 700)); y0 = COORD_W'($urandom_range(0, 520));
        x1 = COORD_W'($urandom_range(0, 700)); y1 = COORD_W'($urandom_range(0, 520));
        start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    red = reduction; nrd = cap_q.size();
    chk({nm, " done_cycle"}, dcyc, n + RD_LAT + 1);
    chk({nm, " busy_gap"}, busy_bad, 0);
    chk({nm, " reduction"}, red, es);
    mism = (cap_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] != exp_q[i]) mism++;
    chk({nm, " addr_seq"}, mism, 0);
    repeat (2) @(negedge clk);
    chk({nm, " idle_after"}, {busy, done}, 0);
    chk({nm, " red_hold"}, reduction, red);
  endtask

  typedef struct {
    int ax0, ay0, ax1, ay1;
    int unsigned pix, wt;
    longint exp_red;
    int exp_done, exp_reads;
  } vec_t;
  vec_t vecs[7];
  int unsigned line1[4] = '{0, 1, 2, 3};
  int unsigned line3[6] = '{0, 640, 1281, 1921, 2562, 3202};

  initial begin
    int dcyc, nrd;
    longint red;
    int unsigned srt[$];
    reset = 1'b0; start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    vecs[0] = '{0, 0, 3, 0, 10, 2, 80, 7, 4};
    vecs[1] = '{5, 5, 5, 5, 511, 15, 7665, 4, 1};
    vecs[2] = '{0, 0, 2, 5, 1, 1, 6, 9, 6};
    vecs[3] = '{2, 5, 0, 0, 1, 1, 6, 9, 6};
    vecs[4] = '{630, 0, 645, 0, 1, 1, 10, 19, 10};
    vecs[5] = '{0, 0, 639, 479, 511, 15, DIAG_RED, 643, 640};
    vecs[6] = '{700, 10, 700, 10, 5, 5, 0, 4, 0};

    repeat (2) @(negedge clk);
    chk("rst sram_rd", sram_rd, 0);
    chk("rst sram_addr", sram_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst reduction", reduction, 0);
    reset = 1'b1;

    const_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cpix = vecs[i].pix; cwt = vecs[i].wt;
      check_chord($sformatf("vec%0d", i), vecs[i].ax0, vecs[i].ay0, vecs[i].ax1, vecs[i].ay1,
                  0, dcyc, red, nrd);
      chk($sformatf("vec%0d tbl_red", i), red, vecs[i].exp_red);
      chk($sformatf("vec%0d tbl_done", i), dcyc, vecs[i].exp_done);
      chk($sformatf("vec%0d tbl_reads", i), nrd, vecs[i].exp_reads);
      srt = cap_q;
      srt.sort();
      if (i == 0) for (int k = 0; k < 4; k++) chk("vec0 pixel", srt[k], line1[k]);
      if (i == 2 || i == 3) for (int k = 0; k < 6; k++) chk("vec23 pixel", srt[k], line3[k]);
    end

    const_mode = 1'b0;
    salt = $urandom;
    for (int r = 0; r < 25; r++) begin
      check_chord($sformatf("rnd%0d", r), $urandom_range(0, 700), $urandom_range(0, 520),
                  $urandom_range(0, 700), $urandom_range(0, 520), (r % 4 == 0) ? 3 : 0,
                  dcyc, red, nrd);
    end

    // Reset in the middle of a long walk.
    @(negedge clk);
    x0 = '0; y0 = '0; x1 = COORD_W'(639); y1 = COORD_W'(479);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst sram_rd", sram_rd, 0);
    chk("midrst sram_addr", sram_addr, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst reduction", reduction, 0);
    @(negedge clk);
    reset = 1'b1;
    check_chord("post_reset", 3, 4, 40, 17, 0, dcyc, red, nrd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
